// File: rtl/pipe_stage.sv
// pipe_stage: two-entry (main + skid) pipeline register stage with halt tracking and stall/bubble counters.
module pipe_stage #(
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e            state_q;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              main_halt_q, skid_halt_q, halt_seen_q, halted_q;
  logic [CNT_W-1:0]  stall_q, bubble_q;
  logic              acc, fire;
  // in_ready depends on registered state only, so no out_ready -> in_ready path
  assign in_ready   = state_q != FULL && !halt_seen_q;
  assign out_valid  = state_q != EMPTY;
  assign acc        = in_valid && in_ready;
  assign fire       = out_valid && out_ready;
  assign out_data   = main_q;
  assign out_halt   = main_halt_q;
  assign halted     = halted_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      main_halt_q <= 1'b0;
      skid_halt_q <= 1'b0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
      stall_q     <= '0;
      bubble_q    <= '0;
    end else begin
      if (out_valid && !out_ready && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (!out_valid && !halted_q && bubble_q != '1) bubble_q <= bubble_q + CNT_W'(1);
      if (flush) begin
        state_q     <= EMPTY;
        main_q      <= '0;
        skid_q      <= '0;
        main_halt_q <= 1'b0;
        skid_halt_q <= 1'b0;
        halt_seen_q <= 1'b0;
      end else begin
        if (acc && in_halt) halt_seen_q <= 1'b1;
        if (fire && main_halt_q) halted_q <= 1'b1;
        case (state_q)
          EMPTY: if (acc) begin
            main_q      <= in_data;
            main_halt_q <= in_halt;
            state_q     <= ONE;
          end
          ONE: if (acc && fire) begin
            main_q      <= in_data;
            main_halt_q <= in_halt;
          end else if (acc) begin
            skid_q      <= in_data;
            skid_halt_q <= in_halt;
            state_q     <= FULL;
          end else if (fire) begin
            state_q <= EMPTY;
          end
          FULL: if (fire) begin
            main_q      <= skid_q;
            main_halt_q <= skid_halt_q;
            state_q     <= ONE;
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end
endmodule
